hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage pipelined CPU, successor to the single-cycle load-use stall unit. It adds the following on top of load-use detection:
- configurable multi-cycle load-use stall length;
- per-operand use qualification;
- data-memory wait freeze;
- branch/jump redirect flush;
- a saturating stall-cycle performance counter.

It sits beside the ID stage and drives the PC write enable, every pipeline-register write enable and the bubble/flush controls.

---
 rtl/hazard_ctrl_if.sv | 40 ++++
 rtl/hazard_ctrl.sv | 124 ++++++++++++
 tb/tb_hazard_ctrl.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline hazard inputs and the stall/flush controls
// driven back to the pipeline. The master is the pipeline; the controller is the slave.
interface hazard_ctrl_if #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  logic              id_ex_mem_rd;
  logic              id_ex_reg_wr;
  logic [REG_AW-1:0] id_ex_rd;
  logic [REG_AW-1:0] if_id_rs1;
  logic [REG_AW-1:0] if_id_rs2;
  logic              if_id_rs1_used;
  logic              if_id_rs2_used;
  logic              ex_redirect;
  logic              mem_req;
  logic              mem_ready;
  logic              pc_wr;
  logic              if_id_wr;
  logic              id_ex_wr;
  logic              ex_mem_wr;
  logic              mem_wb_wr;
  logic              if_id_flush;
  logic              id_ex_flush;
  logic [1:0]        stall_cause;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output id_ex_mem_rd, id_ex_reg_wr, id_ex_rd, if_id_rs1, if_id_rs2,
           if_id_rs1_used, if_id_rs2_used, ex_redirect, mem_req, mem_ready,
    input  pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
           if_id_flush, id_ex_flush, stall_cause, stall_cycles
  );

  modport slave (
    input  id_ex_mem_rd, id_ex_reg_wr, id_ex_rd, if_id_rs1, if_id_rs2,
           if_id_rs1_used, if_id_rs2_used, ex_redirect, mem_req, mem_ready,
    output pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr,
           if_id_flush, id_ex_flush, stall_cause, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: multi-cycle load-use stall, data-memory freeze,
// redirect flush and a saturating stall-cycle counter. Controls are combinational.
module hazard_ctrl #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic          clk,
  input  logic          rstn,
  hazard_ctrl_if.slave  hif
);
  localparam int LW = $clog2(LOAD_LAT + 1);
  localparam logic [LW-1:0] LU_INIT = LW'(LOAD_LAT - 1);

  typedef enum logic [1:0] {IDLE, LU_STALL, MEM_WAIT} state_t;

  state_t           state_q, state_d;
  state_t           resume_q, resume_d;
  state_t           eff_state;
  logic [LW-1:0]    lu_cnt_q, lu_cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic [REG_AW-1:0] ex_rd, rs1, rs2;
  logic              lu_hit, freeze;
  logic              pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr;
  logic              if_id_flush, id_ex_flush;
  logic [1:0]        stall_cause;

  assign ex_rd  = hif.id_ex_rd;
  assign rs1    = hif.if_id_rs1;
  assign rs2    = hif.if_id_rs2;
  assign lu_hit = hif.id_ex_mem_rd & hif.id_ex_reg_wr & (ex_rd != '0) &
                  ((hif.if_id_rs1_used & (rs1 == ex_rd)) |
                   (hif.if_id_rs2_used & (rs2 == ex_rd)));
  assign freeze = hif.mem_req & ~hif.mem_ready;

  // MEM_WAIT is transparent once memory completes: act as the remembered state.
  assign eff_state = (state_q == MEM_WAIT) ? resume_q : state_q;

  always_comb begin
    state_d        = state_q;
    resume_d       = resume_q;
    lu_cnt_d       = lu_cnt_q;
    pc_wr          = 1'b1;
    if_id_wr       = 1'b1;
    id_ex_wr       = 1'b1;
    ex_mem_wr      = 1'b1;
    mem_wb_wr      = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    stall_cause    = 2'b00;

    if (!rstn) begin
      {pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr} = 5'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      state_d     = IDLE;
      resume_d    = IDLE;
      lu_cnt_d    = '0;
    end else if (freeze) begin
      {pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr} = 5'b0;
      stall_cause = 2'b10;
      state_d     = MEM_WAIT;
      resume_d    = eff_state;
    end else begin
      state_d = eff_state;
      if (hif.ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        stall_cause = 2'b11;
        state_d     = IDLE;
        lu_cnt_d    = '0;
      end else if (eff_state == LU_STALL || lu_hit) begin
        pc_wr       = 1'b0;
        if_id_wr    = 1'b0;
        id_ex_flush = 1'b1;
        stall_cause = 2'b01;
        // lu_hit is deliberately ignored while already stalling.
        if (eff_state == LU_STALL) begin
          if (lu_cnt_q <= LW'(1)) begin
            state_d  = IDLE;
            lu_cnt_d = '0;
          end else begin
            state_d  = LU_STALL;
            lu_cnt_d = lu_cnt_q - LW'(1);
          end
        end else if (LOAD_LAT > 1) begin
          state_d  = LU_STALL;
          lu_cnt_d = LU_INIT;
        end else begin
          state_d  = IDLE;
        end
      end
    end

    stall_cycles_d = stall_cycles_q;
    if (!pc_wr && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= IDLE;
      resume_q       <= IDLE;
      lu_cnt_q       <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      resume_q       <= resume_d;
      lu_cnt_q       <= lu_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign hif.pc_wr        = pc_wr;
  assign hif.if_id_wr     = if_id_wr;
  assign hif.id_ex_wr     = id_ex_wr;
  assign hif.ex_mem_wr    = ex_mem_wr;
  assign hif.mem_wb_wr    = mem_wb_wr;
  assign hif.if_id_flush  = if_id_flush;
  assign hif.id_ex_flush  = id_ex_flush;
  assign hif.stall_cause  = stall_cause;
  assign hif.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed, table-driven bench for hazard_ctrl: one DUT with LOAD_LAT=1, one with
// LOAD_LAT=3/CNT_W=4, both fed the same stimulus; each vector checks one DUT.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn = 1'b0;
  logic       mem_rd = 1'b0, reg_wr = 1'b0, u1 = 1'b0, u2 = 1'b0;
  logic       redir = 1'b0, mreq = 1'b0, mrdy = 1'b0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;

  hazard_ctrl_if #(.REG_AW(5), .CNT_W(16)) if1 ();
  hazard_ctrl_if #(.REG_AW(5), .CNT_W(4))  if3 ();

  assign if1.id_ex_mem_rd = mem_rd;   assign if3.id_ex_mem_rd = mem_rd;
  assign if1.id_ex_reg_wr = reg_wr;   assign if3.id_ex_reg_wr = reg_wr;
  assign if1.id_ex_rd     = rd;       assign if3.id_ex_rd     = rd;
  assign if1.if_id_rs1    = rs1;      assign if3.if_id_rs1    = rs1;
  assign if1.if_id_rs2    = rs2;      assign if3.if_id_rs2    = rs2;
  assign if1.if_id_rs1_used = u1;     assign if3.if_id_rs1_used = u1;
  assign if1.if_id_rs2_used = u2;     assign if3.if_id_rs2_used = u2;
  assign if1.ex_redirect  = redir;    assign if3.ex_redirect  = redir;
  assign if1.mem_req      = mreq;     assign if3.mem_req      = mreq;
  assign if1.mem_ready    = mrdy;     assign if3.mem_ready    = mrdy;

  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .CNT_W(16)) u_lat1 (.clk(clk), .rstn(rstn), .hif(if1));
  hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .CNT_W(4))  u_lat3 (.clk(clk), .rstn(rstn), .hif(if3));

  // ctl = {pc_wr, if_id_wr, id_ex_wr, ex_mem_wr, mem_wb_wr, if_id_flush, id_ex_flush}
  localparam logic [6:0] NRM = 7'b11111_00;
  localparam logic [6:0] RST = 7'b00000_11;
  localparam logic [6:0] LU  = 7'b00111_01;
  localparam logic [6:0] FRZ = 7'b00000_00;
  localparam logic [6:0] RED = 7'b11111_11;

  typedef struct {
    int         sel;
    logic       rstn, mem_rd, reg_wr, u1, u2, redir, mreq, mrdy;
    logic [4:0] rd, rs1, rs2;
    logic [6:0] ctl;
    logic [1:0] cause;
    int         cnt;   // -1: counter not checked
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(int sel, logic r, logic ld, logic wr, int d, int s1, int s2,
                              logic a1, logic a2, logic rdr, logic rq, logic ry,
                              logic [6:0] ctl, logic [1:0] cause, int cnt);
    vec_t v;
    v.sel = sel; v.rstn = r; v.mem_rd = ld; v.reg_wr = wr;
    v.rd = 5'(d); v.rs1 = 5'(s1); v.rs2 = 5'(s2);
    v.u1 = a1; v.u2 = a2; v.redir = rdr; v.mreq = rq; v.mrdy = ry;
    v.ctl = ctl; v.cause = cause; v.cnt = cnt;
    return v;
  endfunction

  // Shorthand for an idle pipeline cycle with optional redirect/memory activity.
  function automatic vec_t quiet(int sel, logic rdr, logic rq, logic ry,
                                 logic [6:0] ctl, logic [1:0] cause, int cnt);
    return mk(sel, 1, 0, 0, 0, 0, 0, 0, 0, rdr, rq, ry, ctl, cause, cnt);
  endfunction

  initial begin
    logic [6:0] act_ctl;
    logic [1:0] act_cause;
    int         act_cnt;

    // LOAD_LAT=1: single-cycle stall, rd=x0 and unused-operand exclusions, rs2 path.
    vecs.push_back(mk(0, 0, 0,0, 0,0,0, 0,0, 0,0,0, RST, 2'b00, -1));
    vecs.push_back(quiet(0, 0,0,0, NRM, 2'b00, 0));
    vecs.push_back(mk(0, 1, 1,1, 5,5,0, 1,0, 0,0,0, LU,  2'b01, 0));
    vecs.push_back(mk(0, 1, 0,1, 5,5,0, 1,0, 0,0,0, NRM, 2'b00, 1));
    vecs.push_back(mk(0, 1, 1,1, 0,0,0, 1,1, 0,0,0, NRM, 2'b00, 1));
    vecs.push_back(mk(0, 1, 1,1, 5,5,7, 0,1, 0,0,0, NRM, 2'b00, 1));
    vecs.push_back(mk(0, 1, 1,1, 5,0,5, 0,1, 0,0,0, LU,  2'b01, 1));
    vecs.push_back(mk(0, 1, 1,0, 5,5,0, 1,0, 0,0,0, NRM, 2'b00, 2));
    vecs.push_back(quiet(0, 0,0,0, NRM, 2'b00, 2));

    // LOAD_LAT=3: three-cycle stall on rs2, hazard inputs held during the stall.
    vecs.push_back(mk(1, 0, 0,0, 0,0,0, 0,0, 0,0,0, RST, 2'b00, -1));
    vecs.push_back(quiet(1, 0,0,0, NRM, 2'b00, 0));
    vecs.push_back(mk(1, 1, 1,1, 9,0,9, 0,1, 0,0,0, LU,  2'b01, 0));
    vecs.push_back(mk(1, 1, 1,1, 9,0,9, 0,1, 0,0,0, LU,  2'b01, 1));
    vecs.push_back(quiet(1, 0,0,0, LU,  2'b01, 2));
    vecs.push_back(quiet(1, 0,0,0, NRM, 2'b00, 3));
    // Freeze for two cycles during the second stall cycle: 5 stall cycles total.
    vecs.push_back(mk(1, 1, 1,1, 9,9,0, 1,0, 0,0,0, LU,  2'b01, 3));
    vecs.push_back(quiet(1, 0,1,0, FRZ, 2'b10, 4));
    vecs.push_back(quiet(1, 0,1,0, FRZ, 2'b10, 5));
    vecs.push_back(quiet(1, 0,1,1, LU,  2'b01, 6));
    vecs.push_back(quiet(1, 0,0,0, LU,  2'b01, 7));
    vecs.push_back(quiet(1, 0,0,0, NRM, 2'b00, 8));
    // Redirect in the second stall cycle cancels the rest of the stall.
    vecs.push_back(mk(1, 1, 1,1, 9,9,0, 1,0, 0,0,0, LU,  2'b01, 8));
    vecs.push_back(quiet(1, 1,0,0, RED, 2'b11, 9));
    vecs.push_back(quiet(1, 0,0,0, NRM, 2'b00, 9));
    // Freeze beats redirect; redirect lands on the first unfrozen cycle.
    vecs.push_back(quiet(1, 1,1,0, FRZ, 2'b10, 9));
    vecs.push_back(quiet(1, 1,1,1, RED, 2'b11, 10));
    vecs.push_back(quiet(1, 0,0,0, NRM, 2'b00, 10));
    // Enter a stall, then a long freeze saturating the 4-bit counter.
    vecs.push_back(mk(1, 1, 1,1, 9,9,0, 1,0, 0,0,0, LU,  2'b01, 10));
    for (int i = 0; i < 20; i++)
      vecs.push_back(quiet(1, 0,1,0, FRZ, 2'b10, (11 + i > 15) ? 15 : 11 + i));
    // Reset mid-freeze: remembered stall abandoned, counter cleared.
    vecs.push_back(mk(1, 0, 0,0, 0,0,0, 0,0, 0,1,0, RST, 2'b00, 15));
    vecs.push_back(quiet(1, 0,0,0, NRM, 2'b00, 0));
    vecs.push_back(quiet(1, 0,0,0, NRM, 2'b00, 0));

    foreach (vecs[k]) begin
      @(negedge clk);
      rstn = vecs[k].rstn; mem_rd = vecs[k].mem_rd; reg_wr = vecs[k].reg_wr;
      rd = vecs[k].rd; rs1 = vecs[k].rs1; rs2 = vecs[k].rs2;
      u1 = vecs[k].u1; u2 = vecs[k].u2; redir = vecs[k].redir;
      mreq = vecs[k].mreq; mrdy = vecs[k].mrdy;
      #1;
      if (vecs[k].sel == 0) begin
        act_ctl   = {if1.pc_wr, if1.if_id_wr, if1.id_ex_wr, if1.ex_mem_wr, if1.mem_wb_wr,
                     if1.if_id_flush, if1.id_ex_flush};
        act_cause = if1.stall_cause;
        act_cnt   = int'(if1.stall_cycles);
      end else begin
        act_ctl   = {if3.pc_wr, if3.if_id_wr, if3.id_ex_wr, if3.ex_mem_wr, if3.mem_wb_wr,
                     if3.if_id_flush, if3.id_ex_flush};
        act_cause = if3.stall_cause;
        act_cnt   = int'(if3.stall_cycles);
      end
      $display("vec %0d dut%0d: ctl=%b cause=%b cnt=%0d", k, vecs[k].sel, act_ctl, act_cause, act_cnt);
      n_checks++;
      if (act_ctl !== vecs[k].ctl) begin
        n_fail++;
        $display("FAIL vec%0d ctl: got %b want %b", k, act_ctl, vecs[k].ctl);
      end
      n_checks++;
      if (act_cause !== vecs[k].cause) begin
        n_fail++;
        $display("FAIL vec%0d cause: got %b want %b", k, act_cause, vecs[k].cause);
      end
      if (vecs[k].cnt >= 0) begin
        n_checks++;
        if (act_cnt != vecs[k].cnt) begin
          n_fail++;
          $display("FAIL vec%0d stall_cycles: got %0d want %0d", k, act_cnt, vecs[k].cnt);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
